alu_seq_unit: RTL and testbench

Sequential ALU execution unit: the responder side of the 12-bit one-hot ALU control interface driven by the datapath control logic.
- Accepts an operation with a start/busy/done handshake.
- Completes add/sub/shift/logic/neg/not in one cycle; multiply and divide take 32 iterations.
- Returns a 64-bit result as HI/LO for the HI/LO registers.
- Replaces the combinational multiply/divide path in the bus-architecture datapath.

---
 rtl/alu_seq_unit_if.sv | 28 ++
 rtl/alu_seq_unit.sv | 212 +++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// ALU control interface between the datapath control logic (master) and the
// sequential ALU execution unit (slave). Carries the one-hot op, operands,
// the start/busy/done handshake and the HI/LO result pair.
interface alu_seq_unit_if #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12
);
    logic [SIG_COUNT-1:0] ctrl_signal;
    logic [BITS-1:0]      X;
    logic [BITS-1:0]      Y;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 div_zero;
    logic [BITS-1:0]      OpResult_HI;
    logic [BITS-1:0]      OpResult_LO;

    modport master (
        output ctrl_signal, X, Y, start,
        input  busy, done, err, div_zero, OpResult_HI, OpResult_LO
    );

    modport slave (
        input  ctrl_signal, X, Y, start,
        output busy, done, err, div_zero, OpResult_HI, OpResult_LO
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU execution unit. Single-cycle ops (add/sub/shifts/rotates/
// logic/neg/not, invalid controls and divide-by-zero) complete at the accept
// edge. Multiply (shift-add) and divide (restoring) run one iteration per
// clock on operand magnitudes for BITS clocks, then apply signs and deliver
// a 2*BITS result as {HI, LO}.
module alu_seq_unit #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12
) (
    input logic          clk,
    input logic          clr_n,
    alu_seq_unit_if.slave alu
);
    localparam int SHW = $clog2(BITS);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SHW-1:0]        r_cnt;
    logic                  r_done;
    logic                  r_err;
    logic                  r_div_zero;
    logic [BITS-1:0]       r_hi;
    logic [BITS-1:0]       r_lo;

    // Iteration datapath: mul keeps {partial product, multiplier},
    // div keeps {partial remainder, dividend/quotient}.
    logic [2*BITS-1:0]     r_acc;
    logic [BITS-1:0]       r_opnd;
    logic                  r_neg_lo;
    logic                  r_neg_hi;

    logic signed [BITS-1:0] w_x;
    logic signed [BITS-1:0] w_y;
    logic [BITS-1:0]       w_x_mag;
    logic [BITS-1:0]       w_y_mag;
    logic                  w_onehot;
    logic                  w_accept;
    logic                  w_op_mul;
    logic                  w_op_div;
    logic                  w_div0;
    logic                  w_multi;
    logic                  w_last;
    logic [BITS-1:0]       w_sc_hi;
    logic [BITS-1:0]       w_sc_lo;

    logic [BITS:0]         w_mul_sum;
    logic [2*BITS-1:0]     w_mul_nxt;
    logic [BITS:0]         w_div_sh;
    logic [BITS:0]         w_div_sub;
    logic [2*BITS-1:0]     w_div_nxt;
    logic [2*BITS-1:0]     w_iter_nxt;
    logic [2*BITS-1:0]     w_prod;
    logic [BITS-1:0]       w_fin_hi;
    logic [BITS-1:0]       w_fin_lo;

    // Result of the single-cycle ops; mul/div bits never reach here.
    function automatic logic [BITS-1:0] f_single(
        input logic [SIG_COUNT-1:0] ctrl,
        input logic signed [BITS-1:0] x,
        input logic signed [BITS-1:0] y
    );
        logic [SHW-1:0]    amt;
        logic [2*BITS-1:0] dbl;
        logic [2*BITS-1:0] rr;
        logic [2*BITS-1:0] rl;
        logic [BITS-1:0]   res;
        amt = y[SHW-1:0];
        dbl = {x, x};
        rr  = dbl >> amt;
        rl  = dbl << amt;
        res = '0;
        if (ctrl[0])       res = x + y;
        else if (ctrl[1])  res = x - y;
        else if (ctrl[4])  res = x >> amt;
        else if (ctrl[5])  res = x << amt;
        else if (ctrl[6])  res = rr[BITS-1:0];
        else if (ctrl[7])  res = rl[2*BITS-1:BITS];
        else if (ctrl[8])  res = x & y;
        else if (ctrl[9])  res = x | y;
        else if (ctrl[10]) res = -x;
        else if (ctrl[11]) res = ~x;
        return res;
    endfunction

    assign w_x      = alu.X;
    assign w_y      = alu.Y;
    assign w_x_mag  = w_x[BITS-1] ? -w_x : w_x;
    assign w_y_mag  = w_y[BITS-1] ? -w_y : w_y;
    assign w_onehot = (alu.ctrl_signal != '0) &&
                      ((alu.ctrl_signal & (alu.ctrl_signal - 1'b1)) == '0);
    assign w_accept = alu.start && (r_state == S_IDLE);
    assign w_op_mul = w_onehot && alu.ctrl_signal[2];
    assign w_op_div = w_onehot && alu.ctrl_signal[3];
    assign w_div0   = w_op_div && (alu.Y == '0);
    assign w_multi  = w_op_mul || (w_op_div && !w_div0);
    assign w_last   = (r_state != S_IDLE) && (r_cnt == SHW'(BITS - 1));

    // Single-cycle result selection, including the error and div-by-zero cases.
    always_comb begin
        w_sc_hi = '0;
        w_sc_lo = '0;
        if (!w_onehot) begin
            w_sc_lo = '0;
        end else if (w_div0) begin
            w_sc_hi = alu.X;
            w_sc_lo = '1;
        end else begin
            w_sc_lo = f_single(alu.ctrl_signal, w_x, w_y);
        end
    end

    // One shift-add step (mul) and one restore step (div); the sign bit of
    // the trial subtraction is the borrow that decides the quotient bit.
    assign w_mul_sum  = {1'b0, r_acc[2*BITS-1:BITS]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt  = {w_mul_sum, r_acc[BITS-1:1]};
    assign w_div_sh   = r_acc[2*BITS-1:BITS-1];
    assign w_div_sub  = w_div_sh - {1'b0, r_opnd};
    assign w_div_nxt  = {(w_div_sub[BITS] ? w_div_sh[BITS-1:0] : w_div_sub[BITS-1:0]),
                         r_acc[BITS-2:0], ~w_div_sub[BITS]};
    assign w_iter_nxt = (r_state == S_DIV) ? w_div_nxt : w_mul_nxt;

    // Sign fix-up applied to the final iteration's value at the completion edge.
    always_comb begin
        w_prod   = r_neg_lo ? -w_iter_nxt : w_iter_nxt;
        w_fin_hi = w_prod[2*BITS-1:BITS];
        w_fin_lo = w_prod[BITS-1:0];
        if (r_state == S_DIV) begin
            w_fin_lo = r_neg_lo ? -w_iter_nxt[BITS-1:0] : w_iter_nxt[BITS-1:0];
            w_fin_hi = r_neg_hi ? -w_iter_nxt[2*BITS-1:BITS] : w_iter_nxt[2*BITS-1:BITS];
        end
    end

    // Next-state logic: leave IDLE only for a multi-cycle op, return after the last iteration.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_op_mul)                 w_state_nxt = S_MUL;
                else if (w_accept && w_op_div && !w_div0) w_state_nxt = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Handshake, status flags, iteration count and the held HI/LO results.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_err      <= !w_onehot;
                r_div_zero <= w_div0;
                r_cnt      <= '0;
                if (!w_multi) begin
                    r_done <= 1'b1;
                    r_hi   <= w_sc_hi;
                    r_lo   <= w_sc_lo;
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                    r_hi   <= w_fin_hi;
                    r_lo   <= w_fin_lo;
                end
            end
        end
    end

    // Iteration datapath: load magnitudes and signs at accept, then step once per clock.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_op_div) begin
                r_acc  <= {{BITS{1'b0}}, w_x_mag};
                r_opnd <= w_y_mag;
            end else begin
                r_acc  <= {{BITS{1'b0}}, w_y_mag};
                r_opnd <= w_x_mag;
            end
            r_neg_lo <= w_x[BITS-1] ^ w_y[BITS-1];
            r_neg_hi <= w_x[BITS-1];
        end else if (r_state != S_IDLE) begin
            r_acc <= w_iter_nxt;
        end
    end

    assign alu.busy        = (r_state != S_IDLE);
    assign alu.done        = r_done;
    assign alu.err         = r_err;
    assign alu.div_zero    = r_div_zero;
    assign alu.OpResult_HI = r_hi;
    assign alu.OpResult_LO = r_lo;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit: single-cycle ops, signed mul/div,
// divide by zero, invalid controls, start-while-busy and mid-op reset.
module tb_alu_seq_unit;
    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_MUL = 12'h004;
    localparam logic [11:0] OP_DIV = 12'h008;
    localparam logic [11:0] OP_SHR = 12'h010;
    localparam logic [11:0] OP_SHL = 12'h020;
    localparam logic [11:0] OP_ROR = 12'h040;
    localparam logic [11:0] OP_ROL = 12'h080;
    localparam logic [11:0] OP_AND = 12'h100;
    localparam logic [11:0] OP_OR  = 12'h200;
    localparam logic [11:0] OP_NEG = 12'h400;
    localparam logic [11:0] OP_NOT = 12'h800;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_seq_unit_if a ();

    alu_seq_unit dut (
        .clk   (clk),
        .clr_n (clr_n),
        .alu   (a)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; lat counts cycles from accept.
    task automatic run_op(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int nbusy);
        @(negedge clk);
        a.ctrl_signal = c;
        a.X = x;
        a.Y = y;
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!a.done && lat < 100) begin
            if (a.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [11:0] c, input logic [31:0] x,
                            input logic [31:0] y, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        int nbusy;
        run_op(c, x, y, lat, nbusy);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, {a.OpResult_HI, a.OpResult_LO}, exp_res);
        check_eq({tag, "_busy"}, 64'(nbusy), 64'(exp_lat - 1));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 64'(a.done), 64'd0);
    endtask

    initial begin
        int lat;
        int nbusy;
        int extra;
        a.start = 1'b0;
        a.ctrl_signal = '0;
        a.X = '0;
        a.Y = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(a.busy), 64'd0);
        check_eq("rst_flags", {61'd0, a.done, a.err, a.div_zero}, 64'd0);
        check_eq("rst_res", {a.OpResult_HI, a.OpResult_LO}, 64'd0);
        clr_n = 1'b1;

        op_check("add", OP_ADD, 32'd15, 32'd5, 64'd20, 1);
        op_check("sub", OP_SUB, 32'd15, 32'd5, 64'd10, 1);
        op_check("shr", OP_SHR, 32'd16, 32'd2, 64'd4, 1);
        op_check("shl", OP_SHL, 32'd16, 32'd2, 64'd64, 1);
        op_check("ror", OP_ROR, 32'd16, 32'd2, 64'd4, 1);
        op_check("rol", OP_ROL, 32'd16, 32'd2, 64'd64, 1);
        op_check("ror_wrap", OP_ROR, 32'h0000_0003, 32'd1, 64'h0000_0000_8000_0001, 1);
        op_check("rol_zero", OP_ROL, 32'h1234_5678, 32'd0, 64'h0000_0000_1234_5678, 1);
        op_check("and", OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 64'h0000_0000_00F0_000F, 1);
        op_check("or", OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 64'h0000_0000_FFF0_0FFF, 1);
        op_check("neg", OP_NEG, 32'd15, 32'd0, 64'h0000_0000_FFFF_FFF1, 1);
        op_check("not", OP_NOT, 32'd15, 32'd0, 64'h0000_0000_FFFF_FFF0, 1);
        op_check("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 64'd1, 1);

        op_check("mul_pn", OP_MUL, 32'd15, -32'sd5, 64'hFFFF_FFFF_FFFF_FFB5, 33);
        op_check("mul_np", OP_MUL, -32'sd15, 32'd5, 64'hFFFF_FFFF_FFFF_FFB5, 33);
        op_check("mul_nn", OP_MUL, -32'sd15, -32'sd5, 64'd75, 33);
        op_check("mul_pp", OP_MUL, 32'd15, 32'd5, 64'd75, 33);
        op_check("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
        check_eq("mul_err", {62'd0, a.err, a.div_zero}, 64'd0);

        op_check("div_n_p", OP_DIV, -32'sd17, 32'd5, 64'hFFFF_FFFE_FFFF_FFFD, 33);
        op_check("div_p_n", OP_DIV, 32'd15, -32'sd5, 64'h0000_0000_FFFF_FFFD, 33);
        op_check("div_rem", OP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33);
        op_check("div0", OP_DIV, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1);
        check_eq("div0_flag", {62'd0, a.err, a.div_zero}, 64'd1);

        // Invalid controls, then a valid op clears err.
        op_check("inv_two", 12'b000000000011, 32'd9, 32'd9, 64'd0, 1);
        check_eq("inv_two_err", 64'(a.err), 64'd1);
        op_check("inv_zero", 12'b0, 32'd9, 32'd9, 64'd0, 1);
        check_eq("inv_zero_err", 64'(a.err), 64'd1);
        op_check("add_clr", OP_ADD, 32'd1, 32'd1, 64'd2, 1);
        check_eq("err_clr", {62'd0, a.err, a.div_zero}, 64'd0);

        // Back-to-back single-cycle ops give done on consecutive cycles.
        @(negedge clk);
        a.ctrl_signal = OP_ADD; a.X = 32'd1; a.Y = 32'd2; a.start = 1'b1;
        @(negedge clk);
        check_eq("b2b_done1", 64'(a.done), 64'd1);
        check_eq("b2b_res1", 64'(a.OpResult_LO), 64'd3);
        a.ctrl_signal = OP_SUB; a.X = 32'd9; a.Y = 32'd4;
        @(negedge clk);
        a.start = 1'b0;
        check_eq("b2b_done2", 64'(a.done), 64'd1);
        check_eq("b2b_res2", 64'(a.OpResult_LO), 64'd5);
        @(negedge clk);
        check_eq("b2b_idle", 64'(a.done), 64'd0);

        // start with an add during cycle 10 of a mul is ignored.
        @(negedge clk);
        a.ctrl_signal = OP_MUL; a.X = 32'd7; a.Y = 32'd9; a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        lat = 1;
        while (!a.done && lat < 100) begin
            if (lat == 10) begin
                a.ctrl_signal = OP_ADD; a.X = 32'd3; a.Y = 32'd5; a.start = 1'b1;
            end else begin
                a.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        a.start = 1'b0;
        check_eq("ign_lat", 64'(lat), 64'd33);
        check_eq("ign_res", {a.OpResult_HI, a.OpResult_LO}, 64'd63);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (a.done) extra++;
        end
        check_eq("ign_extra", 64'(extra), 64'd0);

        // Reset pulse during cycle 20 of a div aborts it.
        op_check("pre_rst", OP_DIV, 32'd15, -32'sd5, 64'h0000_0000_FFFF_FFFD, 33);
        @(negedge clk);
        a.ctrl_signal = OP_DIV; a.X = -32'sd17; a.Y = 32'd5; a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("rst_mid_busy_pre", 64'(a.busy), 64'd1);
        clr_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 64'(a.busy), 64'd0);
        check_eq("rst_mid_flags", {61'd0, a.done, a.err, a.div_zero}, 64'd0);
        check_eq("rst_mid_res", {a.OpResult_HI, a.OpResult_LO}, 64'd0);
        #1;
        clr_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (a.done) extra++;
        end
        check_eq("rst_no_done", 64'(extra), 64'd0);
        op_check("post_rst_add", OP_ADD, 32'd3, 32'd5, 64'd8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
